// File: rtl/gbar_core_client_pkg.sv
// Shared definitions for the core-side global barrier client.
package gbar_core_client_pkg;

   localparam int unsigned GBAR_NUM_BARRIERS = 8;
   localparam int unsigned GBAR_NUM_WARPS    = 4;
   localparam int unsigned GBAR_NUM_CORES    = 4;

   localparam int unsigned NB_WIDTH = $clog2(GBAR_NUM_BARRIERS);
   localparam int unsigned NW_WIDTH = $clog2(GBAR_NUM_WARPS);
   localparam int unsigned NC_WIDTH = $clog2(GBAR_NUM_CORES);

   typedef struct packed {
      logic [NB_WIDTH-1:0] id;
      logic [NC_WIDTH-1:0] size_m1;
      logic [NC_WIDTH-1:0] core_id;
   } gbar_req_data_t;

   typedef struct packed {
      logic [NB_WIDTH-1:0] id;
   } gbar_rsp_data_t;

   typedef enum logic [1:0] {
      GB_IDLE    = 2'd0,
      GB_COLLECT = 2'd1,
      GB_SEND    = 2'd2,
      GB_WAIT    = 2'd3
   } gbar_state_e;

endpackage

// File: rtl/gbar_core_client_req_picker.sv
// Lowest-index selection over a vector of request flags.
module gbar_req_picker #(
   parameter int unsigned N  = 8,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  flags,
   output logic          valid,
   output logic [IW-1:0] index
);

   always_comb begin
      valid = |flags;
      index = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (flags[i]) index = IW'(i);
      end
   end

endmodule

// File: rtl/gbar_core_client.sv
// Collects local warp arrivals per global barrier, issues one request per
// barrier to the cluster unit and releases the warps on the broadcast response.
module gbar_core_client
   import gbar_core_client_pkg::*;
#(
   parameter int unsigned NUM_BARRIERS = GBAR_NUM_BARRIERS,
   parameter int unsigned NUM_WARPS    = GBAR_NUM_WARPS,
   parameter int unsigned NUM_CORES    = GBAR_NUM_CORES,
   parameter int unsigned CORE_ID      = 0,
   localparam int unsigned BAR_W  = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
   localparam int unsigned WARP_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   localparam int unsigned CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 arrive_valid,
   output logic                 arrive_ready,
   input  logic [WARP_W-1:0]    arrive_wid,
   input  logic [BAR_W-1:0]     arrive_bar_id,
   input  logic [WARP_W-1:0]    arrive_wcnt_m1,
   input  logic [CORE_W-1:0]    arrive_ccnt_m1,
   output logic                 gbar_req_valid,
   input  logic                 gbar_req_ready,
   output logic [BAR_W-1:0]     gbar_req_id,
   output logic [CORE_W-1:0]    gbar_req_size_m1,
   output logic [CORE_W-1:0]    gbar_req_core_id,
   input  logic                 gbar_rsp_valid,
   input  logic [BAR_W-1:0]     gbar_rsp_id,
   output logic                 release_valid,
   output logic [BAR_W-1:0]     release_bar_id,
   output logic [NUM_WARPS-1:0] release_wmask
);

   localparam int unsigned PC_W = $clog2(NUM_WARPS + 1);

   gbar_state_e              state_q [NUM_BARRIERS];
   gbar_state_e              state_d [NUM_BARRIERS];
   logic [NUM_WARPS-1:0]     mask_q  [NUM_BARRIERS];
   logic [NUM_WARPS-1:0]     mask_d  [NUM_BARRIERS];
   logic [CORE_W-1:0]        ccnt_q  [NUM_BARRIERS];
   logic [CORE_W-1:0]        ccnt_d  [NUM_BARRIERS];

   logic                     req_valid_d;
   logic [BAR_W-1:0]         req_id_d;
   logic [CORE_W-1:0]        req_size_d;
   logic                     rel_valid_d;
   logic [BAR_W-1:0]         rel_id_d;
   logic [NUM_WARPS-1:0]     rel_mask_d;

   logic                     arr_fire;
   logic                     arr_done;
   logic [NUM_WARPS-1:0]     arr_mask;
   logic                     req_fire;
   logic                     rsp_hit;
   logic [NUM_BARRIERS-1:0]  send_flags;
   logic                     pick_valid;
   logic [BAR_W-1:0]         pick_idx;

   function automatic logic [PC_W-1:0] popcount(input logic [NUM_WARPS-1:0] m);
      popcount = '0;
      for (int i = 0; i < NUM_WARPS; i++) popcount = popcount + PC_W'(m[i]);
   endfunction

   assign arrive_ready = (state_q[arrive_bar_id] == GB_IDLE) ||
                         (state_q[arrive_bar_id] == GB_COLLECT);
   assign gbar_req_core_id = CORE_W'(CORE_ID);

   gbar_req_picker #(.N(NUM_BARRIERS), .IW(BAR_W)) u_picker (
      .flags (send_flags),
      .valid (pick_valid),
      .index (pick_idx)
   );

   // Per-barrier next state, request register reload and release pulse.
   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      ccnt_d      = ccnt_q;
      req_valid_d = gbar_req_valid && !gbar_req_ready;
      req_id_d    = gbar_req_id;
      req_size_d  = gbar_req_size_m1;
      rel_valid_d = 1'b0;
      rel_id_d    = release_bar_id;
      rel_mask_d  = '0;

      arr_fire = arrive_valid && arrive_ready;
      arr_mask = mask_q[arrive_bar_id] | (NUM_WARPS'(1) << arrive_wid);
      arr_done = popcount(arr_mask) == (PC_W'(arrive_wcnt_m1) + PC_W'(1));
      req_fire = gbar_req_valid && gbar_req_ready;
      rsp_hit  = gbar_rsp_valid && (state_q[gbar_rsp_id] == GB_WAIT);

      if (arr_fire) begin
         mask_d[arrive_bar_id]  = arr_mask;
         ccnt_d[arrive_bar_id]  = arrive_ccnt_m1;
         state_d[arrive_bar_id] = arr_done ? GB_SEND : GB_COLLECT;
      end
      if (req_fire) state_d[gbar_req_id] = GB_WAIT;
      if (rsp_hit) begin
         state_d[gbar_rsp_id] = GB_IDLE;
         mask_d[gbar_rsp_id]  = '0;
         rel_valid_d          = 1'b1;
         rel_id_d             = gbar_rsp_id;
         rel_mask_d           = mask_q[gbar_rsp_id];
      end

      // A barrier completing this cycle is eligible immediately; the held one never is.
      for (int b = 0; b < NUM_BARRIERS; b++) begin
         send_flags[b] = ((state_q[b] == GB_SEND) ||
                          (arr_fire && arr_done && (arrive_bar_id == BAR_W'(b)))) &&
                         !(gbar_req_valid && (gbar_req_id == BAR_W'(b)));
      end

      if ((!gbar_req_valid || gbar_req_ready) && pick_valid) begin
         req_valid_d = 1'b1;
         req_id_d    = pick_idx;
         req_size_d  = ccnt_d[pick_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int b = 0; b < NUM_BARRIERS; b++) begin
            state_q[b] <= GB_IDLE;
            mask_q[b]  <= '0;
            ccnt_q[b]  <= '0;
         end
         gbar_req_valid   <= 1'b0;
         gbar_req_id      <= '0;
         gbar_req_size_m1 <= '0;
         release_valid    <= 1'b0;
         release_bar_id   <= '0;
         release_wmask    <= '0;
      end else begin
         state_q          <= state_d;
         mask_q           <= mask_d;
         ccnt_q           <= ccnt_d;
         gbar_req_valid   <= req_valid_d;
         gbar_req_id      <= req_id_d;
         gbar_req_size_m1 <= req_size_d;
         release_valid    <= rel_valid_d;
         release_bar_id   <= rel_id_d;
         release_wmask    <= rel_mask_d;
      end
   end

endmodule
